// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte-serial sequencer for the shared byte-wide RAM port.
// Instruction fetch and the load/store stage share one RAM; loads, stores and
// fetches are split into little-endian byte cycles and reassembled here.
module mem_ctrl #(
   parameter int RAM_AW = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   output logic [RAM_AW-1:0] ram_a,
   output logic              ram_wr,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din
);

   typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

   state_t              state, state_n;
   logic [2:0]          cnt, cnt_n;
   logic [2:0]          len, len_n;
   logic [RAM_AW-1:0]   base, base_n;
   logic [31:0]         wr_buf, wr_buf_n;
   logic [31:0]         rd_buf, rd_buf_n;
   logic [RAM_AW-1:0]   ram_a_n;
   logic                ram_wr_n;
   logic [7:0]          ram_dout_n;
   logic                if_done_n;
   logic [31:0]         if_inst_n;
   logic                mem_done_n;
   logic [31:0]         mem_rdata_n;

   logic [2:0]          req_len;
   logic [2:0]          next_idx;
   logic [RAM_AW-1:0]   next_a;
   logic [7:0]          next_wbyte;
   logic [1:0]          cap_idx;
   logic [31:0]         rd_merged;
   logic                unused_addr_bits;

   // Address bits above the RAM width are deliberately dropped.
   assign unused_addr_bits = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

   // Byte count of the pending load/store, the next byte's address/data, and
   // the read buffer with the byte arriving this cycle merged into its lane.
   always_comb begin
      case (mem_size)
         2'd0:    req_len = 3'd1;
         2'd1:    req_len = 3'd2;
         default: req_len = 3'd4;
      endcase
      next_idx   = cnt + 3'd1;
      next_a     = base + RAM_AW'(next_idx);
      next_wbyte = wr_buf[{next_idx[1:0], 3'b000} +: 8];
      cap_idx    = cnt[1:0] - 2'd1;
      rd_merged  = rd_buf;
      rd_merged[{cap_idx, 3'b000} +: 8] = ram_din;
   end

   // Next-state and next-output logic; every register holds unless changed,
   // done pulses and the write strobe default low.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      len_n       = len;
      base_n      = base;
      wr_buf_n    = wr_buf;
      rd_buf_n    = rd_buf;
      ram_a_n     = ram_a;
      ram_wr_n    = 1'b0;
      ram_dout_n  = ram_dout;
      if_done_n   = 1'b0;
      if_inst_n   = if_inst;
      mem_done_n  = 1'b0;
      mem_rdata_n = mem_rdata;
      case (state)
         IDLE: begin
            // The done cycle is never an acceptance cycle: requesters only
            // react to done in the cycle after it.
            if (!if_done && !mem_done) begin
               if (mem_req) begin
                  base_n   = mem_addr[RAM_AW-1:0];
                  len_n    = req_len;
                  cnt_n    = 3'd0;
                  rd_buf_n = 32'd0;
                  ram_a_n  = mem_addr[RAM_AW-1:0];
                  if (mem_we) begin
                     wr_buf_n   = mem_wdata;
                     ram_wr_n   = 1'b1;
                     ram_dout_n = mem_wdata[7:0];
                     state_n    = MEM_WR;
                  end else begin
                     state_n = MEM_RD;
                  end
               end else if (if_req && !if_flush) begin
                  base_n   = if_addr[RAM_AW-1:0];
                  len_n    = 3'd4;
                  cnt_n    = 3'd0;
                  rd_buf_n = 32'd0;
                  ram_a_n  = if_addr[RAM_AW-1:0];
                  state_n  = IF_RD;
               end
            end
         end
         IF_RD, MEM_RD: begin
            if (state == IF_RD && if_flush) begin
               state_n = IDLE;
               cnt_n   = 3'd0;
            end else begin
               if (cnt != 3'd0) begin
                  rd_buf_n = rd_merged;
               end
               if (cnt == len) begin
                  state_n = IDLE;
                  cnt_n   = 3'd0;
                  if (state == IF_RD) begin
                     if_done_n = 1'b1;
                     if_inst_n = rd_merged;
                  end else begin
                     mem_done_n  = 1'b1;
                     mem_rdata_n = rd_merged;
                  end
               end else begin
                  cnt_n = next_idx;
                  if (next_idx != len) begin
                     ram_a_n = next_a;
                  end
               end
            end
         end
         MEM_WR: begin
            if (next_idx == len) begin
               state_n    = IDLE;
               cnt_n      = 3'd0;
               mem_done_n = 1'b1;
            end else begin
               cnt_n      = next_idx;
               ram_a_n    = next_a;
               ram_dout_n = next_wbyte;
               ram_wr_n   = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 3'd0;
         end
      endcase
   end

   // State and registered outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         len       <= 3'd0;
         base      <= '0;
         wr_buf    <= 32'd0;
         rd_buf    <= 32'd0;
         ram_a     <= '0;
         ram_wr    <= 1'b0;
         ram_dout  <= 8'd0;
         if_done   <= 1'b0;
         if_inst   <= 32'd0;
         mem_done  <= 1'b0;
         mem_rdata <= 32'd0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         len       <= len_n;
         base      <= base_n;
         wr_buf    <= wr_buf_n;
         rd_buf    <= rd_buf_n;
         ram_a     <= ram_a_n;
         ram_wr    <= ram_wr_n;
         ram_dout  <= ram_dout_n;
         if_done   <= if_done_n;
         if_inst   <= if_inst_n;
         mem_done  <= mem_done_n;
         mem_rdata <= mem_rdata_n;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a byte RAM model and a
// transaction-level reference (expected byte cycles, done times and data).
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [16:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;

   logic        poke_en;
   logic [16:0] poke_addr;
   logic [7:0]  poke_data;
   logic [7:0]  dev_mem [0:131071];
   logic [7:0]  ref_mem [0:131071];

   int n_checks;
   int n_fail;

   mem_ctrl #(.RAM_AW(17)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
   );

   initial clk = 1'b0;
   // Free-running clock.
   always #5 clk = ~clk;

   // Synchronous byte RAM: read data appears the cycle after its address.
   always @(posedge clk) begin
      if (poke_en) begin
         dev_mem[poke_addr] <= poke_data;
      end else if (ram_wr) begin
         dev_mem[ram_a] <= ram_dout;
      end
      ram_din <= dev_mem[ram_a];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Loads one byte into both the RAM and the reference image (one cycle).
   task automatic setByte(input logic [16:0] a, input logic [7:0] v);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = v;
      ref_mem[a] = v;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   // Presents a load/store and/or a fetch in the same cycle T, builds the
   // expected per-cycle RAM activity and done pulses from the timing rules,
   // and compares every cycle until one cycle after the last done.
   task automatic applyStimulus(input bit do_if, input logic [31:0] f_addr,
                                input bit do_mem, input bit we, input logic [1:0] size,
                                input logic [31:0] m_addr, input logic [31:0] wdata);
      bit          e_wr  [0:31];
      bit          e_av  [0:31];
      bit          e_ifd [0:31];
      bit          e_md  [0:31];
      logic [16:0] e_a   [0:31];
      logic [7:0]  e_d   [0:31];
      logic [31:0] mem_exp;
      logic [31:0] if_exp;
      logic [16:0] a;
      int          s, last, n, md, fd;
      for (int i = 0; i < 32; i++) begin
         e_wr[i] = 0; e_av[i] = 0; e_ifd[i] = 0; e_md[i] = 0;
         e_a[i] = '0; e_d[i] = '0;
      end
      mem_exp = 32'd0;
      if_exp  = 32'd0;
      s = 0; last = 0; md = -1; fd = -1;
      if (do_mem) begin
         n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
         for (int k = 0; k < n; k++) begin
            a = m_addr[16:0] + 17'(k);
            if (we) begin
               e_wr[s+1+k] = 1;
               e_av[s+1+k] = 1;
               e_a[s+1+k]  = a;
               e_d[s+1+k]  = 8'(wdata >> (8*k));
               ref_mem[a]  = 8'(wdata >> (8*k));
            end else begin
               e_av[s+1+k] = 1;
               e_a[s+1+k]  = a;
               mem_exp = mem_exp | (32'(ref_mem[a]) << (8*k));
            end
         end
         md = we ? s + n + 1 : s + n + 2;
         e_md[md] = 1;
         last = md;
         s = md + 1;
      end
      if (do_if) begin
         for (int k = 0; k < 4; k++) begin
            a = f_addr[16:0] + 17'(k);
            e_av[s+1+k] = 1;
            e_a[s+1+k]  = a;
            if_exp = if_exp | (32'(ref_mem[a]) << (8*k));
         end
         fd = s + 6;
         e_ifd[fd] = 1;
         last = fd;
      end
      if_req    = do_if;
      if_addr   = f_addr;
      mem_req   = do_mem;
      mem_we    = we;
      mem_size  = size;
      mem_addr  = m_addr;
      mem_wdata = wdata;
      for (int c = 0; c <= last + 1; c++) begin
         @(negedge clk);
         checkOutput("ram_wr", 32'(ram_wr), 32'(e_wr[c]));
         if (e_av[c]) checkOutput("ram_a", 32'(ram_a), 32'(e_a[c]));
         if (e_wr[c]) checkOutput("ram_dout", 32'(ram_dout), 32'(e_d[c]));
         checkOutput("if_done", 32'(if_done), 32'(e_ifd[c]));
         checkOutput("mem_done", 32'(mem_done), 32'(e_md[c]));
         if (e_md[c]) begin
            if (!we) checkOutput("mem_rdata", mem_rdata, mem_exp);
            mem_req = 1'b0;
         end
         if (e_ifd[c]) begin
            checkOutput("if_inst", if_inst, if_exp);
            if_req = 1'b0;
         end
         if (!do_if) if_flush = 1'($urandom_range(0, 1));
      end
      if_flush = 1'b0;
      mem_req  = 1'b0;
      if_req   = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] r, fa, ma;
      logic [16:0] lo;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0;
      mem_addr = 32'd0; mem_wdata = 32'd0;
      poke_en = 1'b0; poke_addr = '0; poke_data = '0;
      @(posedge clk); #1;
      for (int i = 0; i < 32'h300; i++) setByte(17'(i), 8'($urandom_range(0, 255)));
      for (int i = 32'h1FFE0; i < 32'h20000; i++) setByte(17'(i), 8'($urandom_range(0, 255)));
      setByte(17'h0, 8'h13); setByte(17'h1, 8'h05); setByte(17'h2, 8'h00); setByte(17'h3, 8'h00);
      setByte(17'h100, 8'h78); setByte(17'h101, 8'h56);
      setByte(17'h102, 8'h34); setByte(17'h103, 8'h12);

      @(negedge clk);
      checkOutput("rst_ram_a", 32'(ram_a), 32'd0);
      checkOutput("rst_ram_wr", 32'(ram_wr), 32'd0);
      checkOutput("rst_ram_dout", 32'(ram_dout), 32'd0);
      checkOutput("rst_if_done", 32'(if_done), 32'd0);
      checkOutput("rst_if_inst", if_inst, 32'd0);
      checkOutput("rst_mem_done", 32'(mem_done), 32'd0);
      checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] directed transactions");
      applyStimulus(1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
      checkOutput("fetch0_word", if_inst, 32'h0000_0513);
      applyStimulus(0, 32'h0, 1, 0, 2'd2, 32'h100, 32'h0);
      checkOutput("load_word", mem_rdata, 32'h1234_5678);
      applyStimulus(0, 32'h0, 1, 0, 2'd0, 32'h103, 32'h0);
      checkOutput("load_byte", mem_rdata, 32'h0000_0012);
      applyStimulus(0, 32'h0, 1, 1, 2'd2, 32'h200, 32'hDEAD_BEEF);
      applyStimulus(1, 32'h8, 1, 0, 2'd1, 32'h1FFFF, 32'h0);

      $display("[TB] fetch flush");
      if_req = 1'b1; if_addr = 32'h80;
      @(negedge clk); checkOutput("flush_done_T", 32'(if_done), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); checkOutput("flush_done_T1", 32'(if_done), 32'd0);
      @(posedge clk); #1;
      if_flush = 1'b1;
      @(negedge clk); checkOutput("flush_done_T2", 32'(if_done), 32'd0);
      @(posedge clk); #1;
      if_flush = 1'b0; if_addr = 32'h40;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         checkOutput("flush_if_done", 32'(if_done), 32'(c == 6));
         if (c >= 1 && c <= 4) checkOutput("flush_ram_a", 32'(ram_a), 32'h40 + 32'(c - 1));
         if (c == 6) begin
            checkOutput("flush_if_inst", if_inst,
                        {ref_mem[17'h43], ref_mem[17'h42], ref_mem[17'h41], ref_mem[17'h40]});
            if_req = 1'b0;
         end
      end
      @(posedge clk); #1;

      $display("[TB] reset during store");
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2;
      mem_addr = 32'h200; mem_wdata = 32'hCAFE_BABE;
      @(negedge clk); checkOutput("rs_wr_T", 32'(ram_wr), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rs_wr_T1", 32'(ram_wr), 32'd1);
      checkOutput("rs_a_T1", 32'(ram_a), 32'h200);
      checkOutput("rs_dout_T1", 32'(ram_dout), 32'hBE);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rs_wr_T2", 32'(ram_wr), 32'd1);
      checkOutput("rs_a_T2", 32'(ram_a), 32'h201);
      @(posedge clk); #1;
      rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      ref_mem[17'h200] = 8'hBE;
      ref_mem[17'h201] = 8'hBA;
      @(negedge clk);
      checkOutput("rs_ram_a", 32'(ram_a), 32'd0);
      checkOutput("rs_ram_wr", 32'(ram_wr), 32'd0);
      checkOutput("rs_ram_dout", 32'(ram_dout), 32'd0);
      checkOutput("rs_if_done", 32'(if_done), 32'd0);
      checkOutput("rs_if_inst", if_inst, 32'd0);
      checkOutput("rs_mem_done", 32'(mem_done), 32'd0);
      checkOutput("rs_mem_rdata", mem_rdata, 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("rs_no_done", 32'(mem_done), 32'd0);
         checkOutput("rs_no_wr", 32'(ram_wr), 32'd0);
      end
      @(posedge clk); #1;
      applyStimulus(0, 32'h0, 1, 0, 2'd0, 32'h200, 32'h0);
      checkOutput("rs_byte_kept", mem_rdata, 32'h0000_00BE);
      applyStimulus(0, 32'h0, 1, 0, 2'd2, 32'h200, 32'h0);
      checkOutput("rs_partial", mem_rdata, 32'hDEAD_BABE);

      $display("[TB] random transactions");
      for (int i = 0; i < 150; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         r  = $urandom();
         lo = 17'h1FFF0 + 17'($urandom_range(0, 31));
         ma = {r[31:17], lo};
         r  = $urandom();
         lo = 17'h1FFF0 + 17'($urandom_range(0, 31));
         fa = {r[31:17], lo};
         applyStimulus(kind == 0 || kind == 2, fa, kind != 0, 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), ma, $urandom());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
